// File: rtl/ir_encoder.sv
// ir_encoder: NEC-style pulse-distance IR transmitter for a 32-bit action code
module ir_encoder #(
  parameter int UNIT_CYCLES  = 41766,
  parameter int CARRIER_HALF = 977,
  parameter int MODULATE     = 1,
  parameter int GAP_UNITS    = 64
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        code_in_valid,
  output logic        ir_out,
  output logic        busy_out,
  output logic        done_out
);
  localparam int UCW = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
  localparam int CCW = CARRIER_HALF > 1 ? $clog2(CARRIER_HALF) : 1;
  localparam int MAXU = GAP_UNITS > 16 ? GAP_UNITS : 16;
  localparam int NW = $clog2(MAXU + 1);
  localparam logic [UCW-1:0] U_LAST = UCW'(UNIT_CYCLES - 1);
  localparam logic [CCW-1:0] C_LAST = CCW'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t         state_q, state_d;
  logic [UCW-1:0] ucnt_q, ucnt_d;
  logic [NW-1:0]  units_q, units_d;
  logic [4:0]     bit_q, bit_d;
  logic [31:0]    sr_q, sr_d;
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic           lvl_q, lvl_d, ir_q, ir_d;
  logic           unit_end, state_end, mark_q, mark_d;

  // Frame sequencing: each state runs for units_q whole units, then hands off to the next
  always_comb begin
    unit_end  = ucnt_q == U_LAST;
    state_end = unit_end && units_q == NW'(1);
    state_d   = state_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    ucnt_d    = (state_q == IDLE || unit_end) ? '0 : ucnt_q + 1'b1;
    units_d   = unit_end ? units_q - 1'b1 : units_q;
    done_out  = 1'b0;
    case (state_q)
      IDLE: if (code_in_valid) begin
        state_d = LEAD_MARK;
        units_d = NW'(16);
        sr_d    = code_in;
      end
      LEAD_MARK: if (state_end) begin
        state_d = LEAD_SPACE;
        units_d = NW'(8);
      end
      LEAD_SPACE: if (state_end) begin
        state_d = BIT_MARK;
        units_d = NW'(1);
        bit_d   = 5'd31;
      end
      BIT_MARK: if (state_end) begin
        state_d = BIT_SPACE;
        units_d = sr_q[31] ? NW'(3) : NW'(1);
      end
      BIT_SPACE: if (state_end) begin
        state_d = bit_q == 5'd0 ? STOP_MARK : BIT_MARK;
        units_d = NW'(1);
        bit_d   = bit_q - 1'b1;
        sr_d    = sr_q << 1;
      end
      STOP_MARK: if (state_end) begin
        state_d  = GAP_UNITS == 0 ? IDLE : GAP;
        units_d  = NW'(GAP_UNITS);
        done_out = GAP_UNITS == 0;
      end
      GAP: if (state_end) begin
        state_d  = IDLE;
        done_out = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carrier phase tracks the upcoming state so the registered LED drive lines up with the mark
  always_comb begin
    mark_q = state_q inside {LEAD_MARK, BIT_MARK, STOP_MARK};
    mark_d = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK};
    ccnt_d = '0;
    lvl_d  = 1'b0;
    if (mark_d && !mark_q) begin
      lvl_d = 1'b1;
    end else if (mark_d) begin
      ccnt_d = ccnt_q == C_LAST ? '0 : ccnt_q + 1'b1;
      lvl_d  = ccnt_q == C_LAST ? ~lvl_q : lvl_q;
    end
    ir_d = mark_d && (MODULATE == 0 || lvl_d);
  end

  // State and counter registers; reset aborts any frame in flight
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      ucnt_q  <= '0;
      units_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ccnt_q  <= '0;
      lvl_q   <= 1'b0;
      ir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ucnt_q  <= ucnt_d;
      units_q <= units_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ccnt_q  <= ccnt_d;
      lvl_q   <= lvl_d;
      ir_q    <= ir_d;
    end
  end

  assign ir_out   = ir_q;
  assign busy_out = state_q != IDLE;
endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder: randomized frame checks of ir_encoder against a segment-list waveform model
module tb_ir_encoder;
  localparam int U = 8;
  localparam int CH = 2;
  localparam int NOBS = 1400;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld [3];
  logic [31:0] cin [3];
  logic        ir [3], busy [3], done [3];
  int          n_chk = 0, n_fail = 0;
  logic        obs_ir [NOBS], obs_busy [NOBS], obs_done [NOBS];
  bit          exp_ir [NOBS];
  int          exp_n;
  int          sp_len [32];

  always #5 clk = ~clk;

  ir_encoder #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .MODULATE(0), .GAP_UNITS(4)) u0 (
    .clk_pixel_in(clk), .rst_in(rst), .code_in(cin[0]), .code_in_valid(vld[0]),
    .ir_out(ir[0]), .busy_out(busy[0]), .done_out(done[0]));
  ir_encoder #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .MODULATE(1), .GAP_UNITS(4)) u1 (
    .clk_pixel_in(clk), .rst_in(rst), .code_in(cin[1]), .code_in_valid(vld[1]),
    .ir_out(ir[1]), .busy_out(busy[1]), .done_out(done[1]));
  ir_encoder #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .MODULATE(0), .GAP_UNITS(0)) u2 (
    .clk_pixel_in(clk), .rst_in(rst), .code_in(cin[2]), .code_in_valid(vld[2]),
    .ir_out(ir[2]), .busy_out(busy[2]), .done_out(done[2]));

  task automatic seg(input bit mark, input int units, input int mod);
    for (int p = 0; p < units * U; p++) begin
      exp_n++;
      exp_ir[exp_n] = mark && (mod == 0 || (p / CH) % 2 == 0);
    end
  endtask

  task automatic model(input logic [31:0] code, input int mod, input int gap);
    exp_n = 0;
    seg(1, 16, mod);
    seg(0, 8, mod);
    for (int i = 31; i >= 0; i--) begin
      seg(1, 1, mod);
      seg(0, code[i] ? 3 : 1, mod);
    end
    seg(1, 1, mod);
    seg(0, gap, mod);
  endtask

  task automatic start(input int d, input logic [31:0] code);
    @(negedge clk);
    vld[d] = 1'b1;
    cin[d] = code;
  endtask

  task automatic capture(input int d, input int n, input bit spam, input bit chain, input logic [31:0] next_code);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      obs_ir[k]   = ir[d];
      obs_busy[k] = busy[d];
      obs_done[k] = done[d];
      vld[d] = spam || (chain && k == n);
      cin[d] = (k == n) ? next_code : (spam ? $urandom : cin[d]);
    end
  endtask

  function automatic int frame_errs();
    int c = 0;
    for (int k = 1; k <= exp_n + 1; k++) begin
      if (obs_ir[k] !== (k <= exp_n && exp_ir[k])) c++;
      if (obs_busy[k] !== (k <= exp_n)) c++;
      if (obs_done[k] !== (k == exp_n)) c++;
    end
    return c;
  endfunction

  function automatic int busy_cycles();
    int c = 0;
    for (int k = 1; k <= exp_n + 1; k++) if (obs_busy[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [31:0] decode();
    int k = 1;
    int s;
    logic [31:0] r = '0;
    while (k < NOBS - 1 && obs_ir[k] === 1'b1) k++;
    while (k < NOBS - 1 && obs_ir[k] !== 1'b1) k++;
    for (int i = 0; i < 32; i++) begin
      while (k < NOBS - 1 && obs_ir[k] === 1'b1) k++;
      s = 0;
      while (k < NOBS - 1 && obs_ir[k] !== 1'b1) begin
        s++;
        k++;
      end
      sp_len[i] = s;
      r = {r[30:0], s > 2 * U};
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0;
      cin[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({ir[d], busy[d], done[d]} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: ir/busy/done=%b, required 000", d, {ir[d], busy[d], done[d]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_envelope();
    logic [31:0] codes [3];
    logic [31:0] got;
    int bad;
    codes[0] = 32'hDEADBEEF;
    codes[1] = 32'h20FACADE;
    codes[2] = $urandom;
    foreach (codes[j]) begin
      model(codes[j], 0, 4);
      start(0, codes[j]);
      capture(0, exp_n + 1, 0, 0, '0);
      n_chk++;
      if (frame_errs() !== 0) begin
        n_fail++;
        $display("FAIL envelope_frame code=%h: %0d bad cycles, required 0", codes[j], frame_errs());
      end
      n_chk++;
      if (busy_cycles() !== (89 + 2 * $countones(codes[j]) + 4) * U) begin
        n_fail++;
        $display("FAIL envelope_busy_len code=%h: got %0d, required %0d", codes[j], busy_cycles(),
                 (89 + 2 * $countones(codes[j]) + 4) * U);
      end
      got = decode();
      n_chk++;
      if (got !== codes[j]) begin
        n_fail++;
        $display("FAIL envelope_decode: got %h, required %h", got, codes[j]);
      end
      bad = 0;
      for (int i = 0; i < 32; i++) if (sp_len[i] != (codes[j][31-i] ? 3 * U : U)) bad++;
      n_chk++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL envelope_space_widths code=%h: %0d wrong (first=%0d third=%0d), required 0", codes[j], bad,
                 sp_len[0], sp_len[2]);
      end
    end
  endtask

  task automatic test_modulation();
    logic [31:0] c;
    for (int j = 0; j < 3; j++) begin
      c = (j == 0) ? 32'h20FACADE : $urandom;
      model(c, 1, 4);
      start(1, c);
      capture(1, exp_n + 1, 0, 0, '0);
      n_chk++;
      if (frame_errs() !== 0) begin
        n_fail++;
        $display("FAIL modulated_frame code=%h: %0d bad cycles, required 0", c, frame_errs());
      end
    end
  endtask

  task automatic test_ignore_valid();
    logic [31:0] a, b, got;
    a = $urandom;
    b = $urandom;
    model(a, 0, 4);
    start(0, a);
    capture(0, exp_n + 1, 1, 1, b);
    n_chk++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL ignore_frame code=%h: %0d bad cycles, required 0", a, frame_errs());
    end
    got = decode();
    n_chk++;
    if (got !== a) begin
      n_fail++;
      $display("FAIL ignore_decode: got %h, required %h", got, a);
    end
    model(b, 0, 4);
    capture(0, exp_n + 1, 0, 0, '0);
    n_chk++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL ignore_next_frame code=%h: %0d bad cycles, required 0", b, frame_errs());
    end
    got = decode();
    n_chk++;
    if (got !== b) begin
      n_fail++;
      $display("FAIL ignore_next_decode: got %h, required %h", got, b);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] c, got;
    c = $urandom;
    start(0, c);
    capture(0, 194, 0, 0, '0);
    n_chk++;
    if ({ir[0], busy[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_pre ir/busy=%b, required 11", {ir[0], busy[0]});
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({ir[0], busy[0], done[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL areset_immediate ir/busy/done=%b, required 000", {ir[0], busy[0], done[0]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if ({ir[0], busy[0], done[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL areset_after ir/busy/done=%b, required 000", {ir[0], busy[0], done[0]});
    end
    c = $urandom;
    model(c, 0, 4);
    start(0, c);
    capture(0, exp_n + 1, 0, 0, '0);
    n_chk++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL areset_new_frame code=%h: %0d bad cycles, required 0", c, frame_errs());
    end
    got = decode();
    n_chk++;
    if (got !== c) begin
      n_fail++;
      $display("FAIL areset_decode: got %h, required %h", got, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, got;
    a = 32'hDEADBEEF;
    b = $urandom;
    model(a, 0, 0);
    start(2, a);
    capture(2, exp_n + 1, 0, 1, b);
    n_chk++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL gap0_frame code=%h: %0d bad cycles, required 0", a, frame_errs());
    end
    n_chk++;
    if ({obs_ir[exp_n], obs_done[exp_n]} !== 2'b11) begin
      n_fail++;
      $display("FAIL gap0_done_on_stop ir/done=%b at cycle %0d, required 11", {obs_ir[exp_n], obs_done[exp_n]}, exp_n);
    end
    model(b, 0, 0);
    capture(2, exp_n + 1, 0, 0, '0);
    n_chk++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL gap0_back_to_back code=%h: %0d bad cycles, required 0", b, frame_errs());
    end
    got = decode();
    n_chk++;
    if (got !== b) begin
      n_fail++;
      $display("FAIL gap0_decode: got %h, required %h", got, b);
    end
  endtask

  initial begin
    test_reset();
    test_envelope();
    test_modulation();
    test_ignore_valid();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_encoder.md
Name: ir_encoder

Overview:
- Transmit side of the sword IR link. Takes a 32-bit action code (block 32'hDEADBEEF, lunge 32'h20FACADE) and drives an IR LED with an NEC-style pulse-distance frame.
- The opponent's IR decoder recovers the code and presents it as decoded_ir_in / decoded_ir_in_valid to attack_logic.
- Sits in the controller top level, fed by button/gesture logic. Runs in the clk_pixel_in domain.

Parameters:
- UNIT_CYCLES, 41766, clk cycles per 562.5 us timing unit (74.25 MHz).
- CARRIER_HALF, 977, clk cycles per half period of the ~38 kHz carrier.
- MODULATE, 1, 1 = marks carry the carrier; 0 = marks are a solid high envelope.
- GAP_UNITS, 64, minimum idle units after the stop mark before the next frame is accepted.

Ports:
- clk_pixel_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- code_in  input  32  code to transmit
- code_in_valid  input  1  request; sampled only when busy_out=0
- ir_out  output  1  LED drive
- busy_out  output  1  frame or gap in progress
- done_out  output  1  one-cycle pulse at end of frame+gap

Behaviour:
- Reset (asynchronous, active-high):
  - ir_out=0, busy_out=0, done_out=0, FSM=IDLE, all counters 0.
  - Asserting reset mid-frame aborts the frame immediately. No done_out pulse is produced.
- Accept:
  - In IDLE, code_in_valid=1 latches code_in into a shift register.
  - busy_out goes high the next cycle.
  - code_in_valid is ignored whenever busy_out=1, including the done_out cycle. There is no queuing.
- Frame structure, MSB first; all durations are in units of UNIT_CYCLES:
  - LEAD_MARK 16
  - LEAD_SPACE 8
  - 32 x (BIT_MARK 1, then BIT_SPACE 1 for a '0' or 3 for a '1')
  - STOP_MARK 1
  - GAP GAP_UNITS
  - back to IDLE
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- Counters:
  - A unit counter counts 0..UNIT_CYCLES-1.
  - A unit-count register holds the units remaining in the current state.
  - A 5-bit bit index counts 31 down to 0.
  - BIT_SPACE after bit index 0 goes to STOP_MARK.
- Mark/space timing:
  - The first LEAD_MARK cycle is the cycle after accept.
  - Each state lasts exactly (units x UNIT_CYCLES) cycles with no idle cycles between states.
  - Spaces: ir_out=0.
  - Marks with MODULATE=1: the carrier counter restarts at the first cycle of every mark. ir_out=1 for the first CARRIER_HALF cycles, then toggles every CARRIER_HALF cycles.
  - Marks with MODULATE=0: ir_out=1 throughout.
- ir_out is registered and forced 0 outside mark states.
- End of frame:
  - done_out=1 on the last GAP cycle.
  - busy_out=0 from the following cycle. A new request can be accepted on that cycle.
- Frame length:
  - Units excluding gap = 25 + 2*32 + 2*popcount(code).
  - Total busy cycles = (that + GAP_UNITS) x UNIT_CYCLES.
- Width rules:
  - Counters are sized with $clog2 of their parameters.
  - GAP_UNITS=0 is legal: done_out falls on the last STOP_MARK cycle.

Test Plan:
- UNIT_CYCLES=8, CARRIER_HALF=2, MODULATE=0, GAP_UNITS=4; send 32'hDEADBEEF (popcount 24) -> envelope high for cycles 1..128. busy_out high for (137+4)*8=1128 cycles. Single done_out pulse on the last of them. Decoding the space widths recovers 32'hDEADBEEF.
- Same parameters; send 32'h20FACADE (popcount 17) -> 123 frame units, busy 1016 cycles. The first bit space is 8 cycles ('0'), the third is 24 cycles ('1').
- MODULATE=1, CARRIER_HALF=2 -> during each mark ir_out follows the pattern 1,1,0,0,..., restarting high at every mark start. ir_out=0 during all spaces and the gap.
- Hold code_in_valid high with changing code_in while busy_out=1, including the done_out cycle -> transmitted code unchanged, no extra frame. Valid on the first IDLE cycle -> a new frame starts with LEAD_MARK the next cycle.
- Assert rst_in asynchronously mid BIT_MARK -> ir_out and busy_out drop to 0 without waiting for a clock edge, no done_out. After release, a new request transmits a full correct frame.
- GAP_UNITS=0 -> done_out on the last STOP_MARK cycle. Back-to-back requests give consecutive frames with zero idle cycles beyond the accept cycle.
